// File: rtl/time_display_scan_if.sv
// Bundle between the time register and the display scanner: the six held
// BCD digits going in, the multiplexed 7-segment drive coming out.
interface time_display_scan_if;
  logic [3:0] ht_in;
  logic [3:0] ho_in;
  logic [3:0] mt_in;
  logic [3:0] mo_in;
  logic [3:0] st_in;
  logic [3:0] so_in;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_start;

  // Time-register side: supplies digits, observes the display drive.
  modport master (
    output ht_in, ho_in, mt_in, mo_in, st_in, so_in,
    input  an_n, seg_n, dp_n, frame_start
  );

  // Scanner side: samples digits, drives the display pins.
  modport slave (
    input  ht_in, ho_in, mt_in, mo_in, st_in, so_in,
    output an_n, seg_n, dp_n, frame_start
  );
endinterface

// File: rtl/time_display_scan.sv
// Six-digit common-anode multiplexed display scanner. Digits are snapshotted
// once per frame so a frame never mixes two different times; each slot gets
// one blank (anti-ghosting) cycle followed by TICKS_PER_DIGIT-1 lit cycles.
module time_display_scan #(
  parameter int TICKS_PER_DIGIT = 1000,
  parameter bit BLANK_LEADING   = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  time_display_scan_if.slave  bus
);

  localparam int             CNT_W    = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [2:0]     IDX_LAST = 3'd5;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [3:0]       r_shadow [6];
  logic             r_frame_start;

  logic             w_slot_end;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic             w_suppress;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  assign w_slot_end = (r_cnt == CNT_LAST);

  // Dwell counter, slot index, frame-wrap snapshot and frame_start pulse.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // the shadows are reset too, so the first frame shows defined zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_slot_end) begin
        r_cnt <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx         <= '0;
          r_frame_start <= 1'b1;
          r_shadow[0]   <= bus.ht_in;
          r_shadow[1]   <= bus.ho_in;
          r_shadow[2]   <= bus.mt_in;
          r_shadow[3]   <= bus.mo_in;
          r_shadow[4]   <= bus.st_in;
          r_shadow[5]   <= bus.so_in;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Select the shadow digit for the active slot and decode it.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_digit = r_shadow[0];
    case (r_idx)
      3'd1:    w_digit = r_shadow[1];
      3'd2:    w_digit = r_shadow[2];
      3'd3:    w_digit = r_shadow[3];
      3'd4:    w_digit = r_shadow[4];
      3'd5:    w_digit = r_shadow[5];
      default: w_digit = r_shadow[0];
    endcase
    w_seg      = seg_decode(w_digit);
    w_suppress = BLANK_LEADING && (r_idx == 3'd0) && (w_digit == 4'd0);
  end

  // Display drive: blank on the first cycle of every slot, otherwise light
  // the slot's anode; the hours-tens digit may be suppressed when zero.
  always_comb begin
    bus.an_n  = 6'h3F;
    bus.seg_n = 7'h7F;
    bus.dp_n  = 1'b1;
    if (r_cnt != '0) begin
      bus.an_n  = ~(6'b100000 >> r_idx);
      bus.seg_n = w_suppress ? 7'h7F : w_seg;
      bus.dp_n  = !((r_idx == 3'd1) || (r_idx == 3'd3));
    end
  end

  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan with TICKS_PER_DIGIT = 4. Two instances share
// the digit inputs, one with leading-zero blanking and one without. The
// stimulus process tracks a reference model and pushes the expected outputs
// for each cycle; a monitor pops and compares on the falling edge.
module tb_time_display_scan;

  localparam int T = 4;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg_bl1;
    logic [6:0] seg_bl0;
    logic       dp;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0][3:0] tb_d = '0;   // index 0 = ht ... 5 = so

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Reference model state
  int              m_cnt = 0;
  int              m_idx = 0;
  logic [5:0][3:0] m_sh  = '0;
  logic            m_fs  = 1'b0;

  time_display_scan_if bus1();
  time_display_scan_if bus0();

  assign bus1.ht_in = tb_d[0];
  assign bus1.ho_in = tb_d[1];
  assign bus1.mt_in = tb_d[2];
  assign bus1.mo_in = tb_d[3];
  assign bus1.st_in = tb_d[4];
  assign bus1.so_in = tb_d[5];
  assign bus0.ht_in = tb_d[0];
  assign bus0.ho_in = tb_d[1];
  assign bus0.mt_in = tb_d[2];
  assign bus0.mo_in = tb_d[3];
  assign bus0.st_in = tb_d[4];
  assign bus0.so_in = tb_d[5];

  time_display_scan #(.TICKS_PER_DIGIT(T), .BLANK_LEADING(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  time_display_scan #(.TICKS_PER_DIGIT(T), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [3:0] d;
    e.an = 6'h3F; e.seg_bl1 = 7'h7F; e.seg_bl0 = 7'h7F; e.dp = 1'b1; e.fs = m_fs;
    if (m_cnt != 0) begin
      d         = m_sh[m_idx];
      e.an      = 6'h3F & ~(6'b000001 << (5 - m_idx));
      e.seg_bl0 = seg_ref(d);
      e.seg_bl1 = (m_idx == 0 && d == 4'd0) ? 7'h7F : seg_ref(d);
      e.dp      = !(m_idx == 1 || m_idx == 3);
    end
    return e;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // queue the outputs expected for the cycle that follows.
  task automatic tick();
    logic            rst_s = reset;
    logic [5:0][3:0] d_s   = tb_d;
    @(posedge clk);
    if (rst_s) begin
      m_cnt = 0; m_idx = 0; m_sh = '0; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (m_cnt == T - 1) begin
        m_cnt = 0;
        if (m_idx == 5) begin
          m_idx = 0; m_sh = d_s; m_fs = 1'b1;
        end else begin
          m_idx++;
        end
      end else begin
        m_cnt++;
      end
    end
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare both instances against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an_n_bl1",  {2'b0, bus1.an_n},  {2'b0, e.an});
        check("seg_n_bl1", {1'b0, bus1.seg_n}, {1'b0, e.seg_bl1});
        check("dp_n_bl1",  {7'b0, bus1.dp_n},  {7'b0, e.dp});
        check("fs_bl1",    {7'b0, bus1.frame_start}, {7'b0, e.fs});
        check("an_n_bl0",  {2'b0, bus0.an_n},  {2'b0, e.an});
        check("seg_n_bl0", {1'b0, bus0.seg_n}, {1'b0, e.seg_bl0});
        check("dp_n_bl0",  {7'b0, bus0.dp_n},  {7'b0, e.dp});
        check("fs_bl0",    {7'b0, bus0.frame_start}, {7'b0, e.fs});
      end
    end
  end

  // Directed stimulus
  initial begin
    int guard;
    int rel_cycles;
    bit seen;

    // Reset held three cycles, then released with 1..6 presented.
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    tb_d = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    // First frame shows zero shadows; frame_start lands on release cycle 24.
    rel_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      rel_cycles++;
      if (bus1.frame_start && !seen) begin
        seen = 1'b1;
        check("frame_start_cycle", 8'(rel_cycles), 8'd24);
      end
    end
    if (!seen) check("frame_start_seen", 8'd0, 8'd1);

    // Frame showing 1..6; switch to all eights mid-frame.
    run(10);
    tb_d = {6{4'd8}};
    run(14);
    run(24);                      // all-eights frame

    // Leading-zero blanking, then an illegal code in the hours-ones slot.
    tb_d = {4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd0};
    run(48);
    tb_d = {4'd1, 4'd1, 4'd1, 4'd1, 4'hC, 4'd1};
    run(48);

    // Reset edge on cycle 13 of a frame (slot 3, cnt 1).
    guard = 0;
    while (!(m_idx == 3 && m_cnt == 0) && guard < 30) begin
      tick();
      guard++;
    end
    if (guard >= 30) check("align_timeout", 8'(guard), 8'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(30);

    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Reader side of the time register: takes the six held BCD time digits (hours tens/ones, minutes tens/ones, seconds tens/ones) and drives a six-digit, common-anode, multiplexed 7-segment display. The block snapshots all six digits once per scan frame so that no frame mixes digits from two different times. It also cycles the digit enables with a programmable dwell and decodes each digit to active-low segments. It sits between the time register and the board display pins.

## Interface
- TICKS_PER_DIGIT, default 1000: clock cycles each digit is enabled per frame, including its blanking cycle; legal values are ≥ 2.
- BLANK_LEADING, default 1: when 1, a zero hours-tens digit is displayed blank.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ht_in, ho_in, mt_in, mo_in, st_in, so_in  in  4 each  BCD digits from the time register; hours tens/ones, minutes tens/ones, seconds tens/ones
- an_n  out  6  active-low digit enables, one-hot or all-ones; bit 5 = ht (leftmost), bit 0 = so (rightmost)
- seg_n  out  7  active-low segments, {g,f,e,d,c,b,a}
- dp_n  out  1  active-low separator dot
- frame_start  out  1  one-cycle pulse marking the start of a new frame after a snapshot

## Operation
- State registers:
  - cnt: 0..TICKS_PER_DIGIT-1, dwell counter.
  - idx: 0..5, slot; 0 = ht, 1 = ho, 2 = mt, 3 = mo, 4 = st, 5 = so.
  - Six 4-bit shadow digits.
  - frame_start flop.
- Every cycle, cnt increments.
- When cnt = TICKS_PER_DIGIT-1, the following happen on the next edge:
  - cnt returns to 0.
  - idx advances; 5 wraps to 0.
  - If idx = 5 (frame wrap): all six shadows load the current inputs and frame_start is set to 1.
- frame_start is 0 on every other edge.
- Inputs never reach the outputs except through the shadows.
- Outputs are a combinational decode of the registered state only:
  - Blank slot cycle: cnt = 0 → an_n = 6'h3F, seg_n = 7'h7F, dp_n = 1. This is anti-ghosting.
  - Otherwise an_n drives the bit for slot idx low and all other bits high.
  - Suppressed digit: slot 0 with BLANK_LEADING = 1 and shadow ht = 0 → an_n stays enabled, seg_n = 7'h7F, dp_n = 1.
- Segment decode for the shadow digit of slot idx:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Values 10..15 → 7'h3F (segment g only, "-").
- dp_n = 0 on slots 1 and 3 (the hh.mm.ss separators) when not blanked; 1 otherwise.
- Frame length is exactly 6 × TICKS_PER_DIGIT cycles.
- Input changes inside a frame are ignored until the next wrap.

## Timing
- Reset values, during reset and on the first edge after it:
  - cnt = 0, idx = 0, shadows = 0, frame_start = 0.
  - Outputs: an_n = 6'h3F, seg_n = 7'h7F, dp_n = 1.
- The first frame after reset displays the zero shadows: ht suppressed (if BLANK_LEADING), every other digit 0.
- The first snapshot occurs 6 × TICKS_PER_DIGIT edges after reset release.
  - On that edge, the new shadows, idx = 0, cnt = 0 and frame_start = 1 all appear together.
- Input-to-display latency: at most 6 × TICKS_PER_DIGIT + 1 cycles.
- Reset asserted mid-frame: state returns to the reset values on that edge; partial snapshots cannot occur.
- Simultaneous input change and wrap edge: the value sampled on that edge is the one displayed.

## Test plan
- Reset, TICKS_PER_DIGIT = 4:
  - Hold reset 3 cycles → an_n = 3F, seg_n = 7F, dp_n = 1, frame_start = 0 throughout.
  - After release, 24 cycles with an_n pattern 3F, 1F, 1F, 1F, 3F, 2F, 2F, 2F, … one-hot per slot.
- Inputs 1,2,3,4,5,6 applied before the first wrap:
  - frame_start high exactly at cycle 24 after release.
  - Next frame seg_n per slot = 79, 24, 30, 19, 12, 02.
  - dp_n = 0 only in slots 1 and 3, and not in their cnt = 0 cycle.
- Inputs 0,9,5,9,5,9 with BLANK_LEADING = 1 → slot 0 has an_n bit 5 low and seg_n = 7F; slot 1 seg_n = 10. With BLANK_LEADING = 0 → slot 0 seg_n = 40.
- Change inputs from 1,2,3,4,5,6 to 8,8,8,8,8,8 mid-frame:
  - The current frame still shows 1..6.
  - The next frame shows seg_n = 00 on all slots.
- Illegal digit ho_in = 4'hC → seg_n = 3F in slot 1.
- Assert reset at cycle 13 of a frame → outputs and frame_start take their reset values on that edge, and the scan restarts at slot 0.
